// File: rtl/floating_multiply.sv
// Single-cycle IEEE-754 binary32 multiplier with round-to-nearest-even and flush-to-zero.
// Exposes the upper 32 bits of the significand product for debug.
module floating_multiply (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] value,
  output logic [31:0] debug,
  input  logic        clk,
  input  logic        rst
);

  logic [7:0]         exp_a;
  logic [7:0]         exp_b;
  logic [22:0]        frac_a;
  logic [22:0]        frac_b;
  logic               sign;
  logic               a_nan;
  logic               b_nan;
  logic               a_inf;
  logic               b_inf;
  logic               a_zero;
  logic               b_zero;
  logic [23:0]        sig_a;
  logic [23:0]        sig_b;
  logic [47:0]        prod;
  logic signed [10:0] exp_unrounded;
  logic signed [10:0] exp_norm;
  logic signed [10:0] exp_final;
  logic [22:0]        frac_norm;
  logic [22:0]        frac_final;
  logic [23:0]        frac_inc;
  logic               guard;
  logic               sticky;
  logic               round_up;
  logic [31:0]        value_next;
  logic [31:0]        debug_next;

  assign exp_a  = a[30:23];
  assign exp_b  = b[30:23];
  assign frac_a = a[22:0];
  assign frac_b = b[22:0];
  assign sign   = a[31] ^ b[31];

  assign a_nan  = (exp_a == 8'hFF) && (frac_a != 23'd0);
  assign b_nan  = (exp_b == 8'hFF) && (frac_b != 23'd0);
  assign a_inf  = (exp_a == 8'hFF) && (frac_a == 23'd0);
  assign b_inf  = (exp_b == 8'hFF) && (frac_b == 23'd0);
  // exp==0 covers both true zero and subnormals, which are flushed here
  assign a_zero = (exp_a == 8'd0);
  assign b_zero = (exp_b == 8'd0);

  assign sig_a = a_zero ? 24'd0 : {1'b1, frac_a};
  assign sig_b = b_zero ? 24'd0 : {1'b1, frac_b};
  assign prod  = sig_a * sig_b;

  assign exp_unrounded = $signed({3'b000, exp_a}) + $signed({3'b000, exp_b}) - 11'sd127;

  always_comb begin
    frac_norm = prod[45:23];
    guard     = prod[22];
    sticky    = |prod[21:0];
    exp_norm  = exp_unrounded;
    if (prod[47]) begin
      frac_norm = prod[46:24];
      guard     = prod[23];
      sticky    = |prod[22:0];
      exp_norm  = exp_unrounded + 11'sd1;
    end
  end

  // Ties-to-even: on an exact half, round up only when the kept LSB is odd
  assign round_up = guard & (sticky | frac_norm[0]);
  assign frac_inc = {1'b0, frac_norm} + 24'd1;

  always_comb begin
    frac_final = frac_norm;
    exp_final  = exp_norm;
    if (round_up) begin
      if (frac_inc[23]) begin
        frac_final = 23'd0;
        exp_final  = exp_norm + 11'sd1;
      end else begin
        frac_final = frac_inc[22:0];
      end
    end
  end

  always_comb begin
    value_next = {sign, exp_final[7:0], frac_final};
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      value_next = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      value_next = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      value_next = {sign, 31'd0};
    end else if (exp_final <= 11'sd0) begin
      value_next = {sign, 31'd0};
    end else if (exp_final >= 11'sd255) begin
      value_next = {sign, 8'hFF, 23'd0};
    end
  end

  // A zero operand has a zero significand, so debug is naturally 0 for zero products
  assign debug_next = prod[47:16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= 32'd0;
      debug <= 32'd0;
    end else begin
      value <= value_next;
      debug <= debug_next;
    end
  end

endmodule

// File: tb/tb_floating_multiply.sv
// Directed-vector bench for floating_multiply: table of hand-computed products
// plus an asynchronous reset sequence.
module tb_floating_multiply;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] value;
  logic [31:0] debug;

  int checks;
  int errors;

  floating_multiply dut (
    .a     (a),
    .b     (b),
    .value (value),
    .debug (debug),
    .clk   (clk),
    .rst   (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] value;
    logic        check_debug;
    logic [31:0] debug;
  } vec_t;

  vec_t vecs[18];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{"1000*-10",        32'h447A0000, 32'hC1200000, 32'hC61C4000, 1'b1, 32'h9C400000};
    vecs[1]  = '{"32*32",           32'h42000000, 32'h42000000, 32'h44800000, 1'b1, 32'h40000000};
    vecs[2]  = '{"-0*5",            32'h80000000, 32'h40A00000, 32'h80000000, 1'b1, 32'h00000000};
    vecs[3]  = '{"sticky_round",    32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b1, 32'h40000100};
    vecs[4]  = '{"overflow",        32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 1'b1, 32'h7FFFFF80};
    vecs[5]  = '{"zero*inf",        32'h00000000, 32'h7F800000, 32'h7FC00000, 1'b0, 32'h0};
    vecs[6]  = '{"nan*1",           32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 32'h0};
    vecs[7]  = '{"underflow",       32'h00800000, 32'h00800000, 32'h00000000, 1'b1, 32'h40000000};
    vecs[8]  = '{"subnormal_flush", 32'h00000001, 32'h3F800000, 32'h00000000, 1'b1, 32'h00000000};
    vecs[9]  = '{"1.5*1.5",         32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b1, 32'h90000000};
    vecs[10] = '{"tie_round_up",    32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0, 32'h0};
    vecs[11] = '{"tie_round_down",  32'h3F800003, 32'h3FC00000, 32'h3FC00004, 1'b0, 32'h0};
    vecs[12] = '{"round_carry",     32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 1'b1, 32'h7FFFFFFF};
    vecs[13] = '{"inf*-2",          32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0, 32'h0};
    vecs[14] = '{"inf*inf",         32'h7F800000, 32'hFF800000, 32'hFF800000, 1'b0, 32'h0};
    vecs[15] = '{"1*nan_b",         32'h3F800000, 32'hFF800001, 32'h7FC00000, 1'b0, 32'h0};
    vecs[16] = '{"neg_underflow",   32'h00800000, 32'h80800000, 32'h80000000, 1'b0, 32'h0};
    vecs[17] = '{"inf*-0",          32'hFF800000, 32'h00000000, 32'h7FC00000, 1'b0, 32'h0};

    rst = 1'b1;
    a   = 32'h447A0000;
    b   = 32'hC1200000;
    #12;
    check32("reset_value", value, 32'h0);
    check32("reset_debug", debug, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      a = vecs[i].a;
      b = vecs[i].b;
      @(posedge clk);
      #1;
      check32({vecs[i].name, "_value"}, value, vecs[i].value);
      if (vecs[i].check_debug) begin
        check32({vecs[i].name, "_debug"}, debug, vecs[i].debug);
      end
    end

    // Load a nonzero product, then assert reset between edges
    @(negedge clk);
    a = 32'h447A0000;
    b = 32'hC1200000;
    @(posedge clk);
    #1;
    check32("pre_rst_value", value, 32'hC61C4000);
    #2;
    rst = 1'b1;
    #1;
    check32("async_rst_value", value, 32'h0);
    check32("async_rst_debug", debug, 32'h0);
    @(posedge clk);
    #1;
    check32("held_rst_value", value, 32'h0);
    check32("held_rst_debug", debug, 32'h0);
    @(negedge clk);
    a   = 32'h42000000;
    b   = 32'h42000000;
    rst = 1'b0;
    #1;
    check32("rst_release_no_edge", value, 32'h0);
    @(posedge clk);
    #1;
    check32("post_rst_value", value, 32'h44800000);
    check32("post_rst_debug", debug, 32'h40000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/floating_multiply.md
FLOATING_MULTIPLY -- requirements
Module: floating_multiply

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port a, input, 32 bits: IEEE-754 binary32 multiplicand.
REQ-004 SHALL have port b, input, 32 bits: IEEE-754 binary32 multiplier.
REQ-005 SHALL have port value, output, 32 bits: registered binary32 product a*b.
REQ-006 SHALL have port debug, output, 32 bits: registered bits [47:16] of the 48-bit significand product.
REQ-007 SHALL declare ports in positional order a, b, value, debug, clk, rst, so that existing positional instantiations (a, b, value, debug, clk) stay valid.

Function
REQ-008 SHALL compute value combinationally from a and b and register it on each rising clk edge: latency 1 cycle, throughput 1 per cycle, no handshake.
REQ-009 SHALL register debug on the same edge as value, from the same a/b operands.
REQ-010 SHALL set the result sign to sign(a) XOR sign(b) for every result class, including zero, infinity and overflow.
REQ-011 SHALL form significands as {1, frac} for normal operands; the 24x24 product gives a 48-bit significand product.
REQ-012 SHALL set the unrounded exponent to exp(a) + exp(b) - 127, computed at least 10 bits wide and signed.
REQ-013 SHALL, when product bit 47 is 1, take the fraction from bits [46:24] and increment the exponent; otherwise take it from bits [45:23].
REQ-014 SHALL round to nearest, ties to even, using the guard bit and a sticky OR of all lower bits.
REQ-015 SHALL handle a rounding carry out of the fraction by incrementing the exponent and zeroing the fraction.
REQ-016 SHALL flush subnormal operands (exp=0, frac!=0) to zero before the multiply.
REQ-017 SHALL return a signed zero when the final exponent is <= 0.
REQ-018 SHALL return a signed infinity (exp=255, frac=0) when the final exponent is >= 255.
REQ-019 SHALL return the canonical NaN 0x7FC00000 when either operand is NaN, or for zero times infinity.
REQ-020 SHALL return a signed infinity for infinity times a nonzero finite or infinite operand.
REQ-021 SHALL return a signed zero, with debug = 0, when either operand is zero (or flushed subnormal) and the other is not infinity or NaN.
REQ-022 SHALL generate no exception flags.

Reset
REQ-023 SHALL clear value and debug to 0x00000000 immediately when rst is asserted, without waiting for a clock edge.
REQ-024 SHALL keep value and debug at zero while rst is high.
REQ-025 SHALL load the product of the current a/b on the first rising clk edge after rst deasserts; an operation in flight when reset asserts is discarded.

Verification
REQ-026 Bench SHALL apply a=0x447A0000 (1000), b=0xC1200000 (-10) -> one edge later value=0xC61C4000 (-10000), debug=0x9C400000.
REQ-027 Bench SHALL apply a=b=0x42000000 (32) -> value=0x44800000 (1024); and a=0x80000000 (-0), b=0x40A00000 (5) -> value=0x80000000.
REQ-028 Bench SHALL apply a=b=0x3F800001 -> value=0x3F800002 (rounding with sticky); and a=0x7F7FFFFF, b=0x40000000 -> value=0x7F800000 (overflow).
REQ-029 Bench SHALL apply a=0x00000000, b=0x7F800000 -> value=0x7FC00000; and a=0x7FC00001, b=0x3F800000 -> value=0x7FC00000.
REQ-030 Bench SHALL apply a=b=0x00800000 (min normal) -> value=0x00000000 (underflow flush); and a=0x00000001 (subnormal), b=0x3F800000 -> value=0x00000000.
REQ-031 Bench SHALL assert rst mid-stream between clock edges -> value and debug read 0x00000000 before the next edge; after deassert, the first edge yields the current product.
